mem_access_unit: RTL
====================

# mem_access_unit

Initiator-side controller between the CPU datapath and the byte-addressed, little-endian data memory. It accepts one load or store request at a time (byte, halfword or word), drives the memory's address, data, read and write strobes, and returns a one-cycle completion pulse with an extended load result. The memory only writes full 32-bit words, so byte and halfword stores use a read-modify-write sequence. Alignment and range errors are detected before any memory access.

## Interface
Parameters:
- MEM_BYTES, 1024: data memory size in bytes; the highest legal byte touched is MEM_BYTES-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- is_store  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 halfword, 10 word; 11 is illegal and raises err.
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  32  byte address.
- store_data  in  32  store source; low byte or halfword used for sub-word stores.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = request rejected, no memory access made.
- load_data  out  32  extended load result, held until the next successful load.
- mem_address  out  32  memory byte address.
- mem_write_data  out  32  memory write word.
- mem_read  out  1  memory read enable; memory read data is combinational.
- mem_write  out  1  memory write enable; memory commits on the rising edge.
- mem_read_data  in  32  word from memory, with byte at mem_address in [7:0].

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE, start=1: latch is_store, size, sign_ext, addr and store_data. Then check the request:
  - Error, next state DONE with err latched: size=11; halfword with addr[0]≠0; word with addr[1:0]≠0; addr+3 > MEM_BYTES-1, computed at 33 bits so it cannot wrap.
  - Load: next state READ.
  - Word store: next state WRITE.
  - Byte or halfword store: next state READ.
- READ:
  - mem_read=1 and mem_address=latched addr.
  - Capture mem_read_data into an internal word register at the edge.
  - Next state is DONE for a load, WRITE for a sub-word store.
- WRITE:
  - mem_write=1 and mem_address=latched addr.
  - mem_write_data is store_data for a word store.
  - For a byte store it is {captured[31:8], store_data[7:0]}.
  - For a halfword store it is {captured[31:16], store_data[15:0]}.
  - Next state DONE.
- DONE:
  - done=1 for one cycle.
  - For a successful load, load_data is updated at the READ→DONE edge:
    - byte: {24×(sign_ext & b[7]), b[7:0]}
    - halfword: {16×(sign_ext & h[15]), h[15:0]}
    - word: unchanged
  - Next state IDLE.
- start outside IDLE is ignored. It is not queued.
- A store or an err completion leaves load_data unchanged.
- mem_read and mem_write are never high in the same cycle. Both are 0 in IDLE and DONE.

## Timing
- Reset values: state IDLE; busy, done, err, mem_read, mem_write all 0; load_data, mem_address and mem_write_data all 0.
- Asserting rst mid-operation drops mem_write and mem_read immediately, because the strobes are decoded from the asynchronously reset state. A partially performed read-modify-write leaves memory unmodified.
- Latency from the start-sampling edge to done high:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- Back-to-back requests: the earliest next start is sampled in the cycle after done. That gives 3, 3, 4 and 2 cycle issue intervals respectively.
- Strobes and mem_* outputs are decoded from registered state and latched fields only. There is no combinational path from start or addr to the memory.

## Structure
- Shared package: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state enum, and the default MEM_BYTES constant.
- One sub-module, mem_lane_merge, which is purely combinational. It produces the load extension result from (size, sign_ext, word) and the store merge word from (size, captured, store_data). The FSM stays in mem_access_unit.

## Test plan
- Word store, then load: store 0xDEADBEEF at 0x10, then load word from 0x10. Expect done at +2 both times, err=0, load_data=0xDEADBEEF.
- Byte read-modify-write: memory at 0x20 holds 0x11223344. Store byte 0xAB. Expect READ then WRITE with mem_write_data=0x112233AB, done at +3. Reloading the word returns 0x112233AB.
- Extension: memory word 0x0000F080 at 0x30.
  - Byte load with sign_ext=1 returns 0xFFFFFF80; with sign_ext=0 returns 0x00000080.
  - Halfword load with sign_ext=1 returns 0xFFFFF080.
- Errors: halfword at 0x31, word at 0x32, size=11, and word at MEM_BYTES-2. Each gives done and err at +1, mem_read and mem_write stay 0, load_data unchanged.
- Busy and reset: start pulsed during READ is ignored. rst asserted during the WRITE cycle of a sub-word store drops mem_write the same cycle, returns to IDLE, and leaves all outputs at their reset values.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: size codes, FSM states,
// latched request payload and the request legality check.
package mem_access_unit_pkg;

    localparam int unsigned MEM_BYTES_DEFAULT = 1024;
    localparam int unsigned ADDR_W            = 32;
    localparam int unsigned DATA_W            = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic              is_store;
        logic [1:0]        size;
        logic              sign_ext;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] store_data;
    } req_t;

    // The range test always covers four bytes from addr, computed one bit wider so it cannot wrap.
    function automatic logic req_illegal(input logic [1:0] sz, input logic [ADDR_W-1:0] a,
                                         input int unsigned mem_bytes);
        logic [ADDR_W:0] last_byte;
        logic [ADDR_W:0] limit;
        logic            misaligned;
        last_byte = {1'b0, a} + (ADDR_W+1)'(3);
        limit     = (ADDR_W+1)'(mem_bytes) - (ADDR_W+1)'(1);
        case (sz)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = a[0];
            SZ_WORD: misaligned = (a[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
        return misaligned || (last_byte > limit);
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_merge.sv
// Byte-lane datapath: load extension and read-modify-write store merge.
module mem_lane_merge
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [DATA_W-1:0] word,
    input  logic [DATA_W-1:0] captured,
    input  logic [DATA_W-1:0] store_data,
    output logic [DATA_W-1:0] load_word,
    output logic [DATA_W-1:0] store_word
);

    always_comb begin
        load_word  = word;
        store_word = store_data;
        case (size)
            SZ_BYTE: begin
                load_word  = {{24{sign_ext & word[7]}}, word[7:0]};
                store_word = {captured[31:8], store_data[7:0]};
            end
            SZ_HALF: begin
                load_word  = {{16{sign_ext & word[15]}}, word[15:0]};
                store_word = {captured[31:16], store_data[15:0]};
            end
            default: begin
                load_word  = word;
                store_word = store_data;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-request load/store controller for a word-write, byte-addressed memory.
// Sub-word stores are performed as read-modify-write.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_store,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] load_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data
);

    state_t            state;
    req_t              req_q;
    logic [DATA_W-1:0] captured;
    logic [DATA_W-1:0] load_ext;
    logic [DATA_W-1:0] store_merge;
    logic              illegal;

    assign illegal = req_illegal(size, addr, MEM_BYTES);

    mem_lane_merge u_lane_merge (
        .size       (req_q.size),
        .sign_ext   (req_q.sign_ext),
        .word       (mem_read_data),
        .captured   (captured),
        .store_data (req_q.store_data),
        .load_word  (load_ext),
        .store_word (store_merge)
    );

    // Request sequencing; a word store skips the read phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            req_q     <= '0;
            captured  <= '0;
            err       <= 1'b0;
            load_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        req_q <= '{is_store: is_store, size: size, sign_ext: sign_ext,
                                   addr: addr, store_data: store_data};
                        err   <= illegal;
                        if (illegal)
                            state <= ST_DONE;
                        else if (is_store && size == SZ_WORD)
                            state <= ST_WRITE;
                        else
                            state <= ST_READ;
                    end
                end
                ST_READ: begin
                    captured <= mem_read_data;
                    if (req_q.is_store) begin
                        state <= ST_WRITE;
                    end else begin
                        load_data <= load_ext;
                        state     <= ST_DONE;
                    end
                end
                ST_WRITE: state <= ST_DONE;
                ST_DONE: begin
                    err   <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Memory side is decoded from the reset-cleared state, so rst drops the strobes at once.
    assign busy           = (state != ST_IDLE);
    assign done           = (state == ST_DONE);
    assign mem_read       = (state == ST_READ);
    assign mem_write      = (state == ST_WRITE);
    assign mem_address    = req_q.addr;
    assign mem_write_data = store_merge;

endmodule
